preg_alloc_ctrl: RTL and testbench
==================================

Name: preg_alloc_ctrl

Overview:
Controller that sequences the physical-register free list for the out-of-order core.
- Serves one rename-stage allocation per cycle and returns one committed physical register per cycle.
- Returns squashed physical registers during a flush walk from the ROB.
- Arbitrates the free list's single enqueue port between commit frees and squash frees.
- Tracks the free-register count so rename never dequeues from an empty list.

Parameters:
DATA_WIDTH, 6, physical register index width
QUEUE_DEPTH, 32, free list capacity; also the free count at reset (list starts full)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_req_in  in  1  rename requests one physical register this cycle
alloc_ready_out  out  1  allocation can be granted this cycle
alloc_valid_out  out  1  grant; alloc_preg_out is valid
alloc_preg_out  out  DATA_WIDTH  granted physical register
commit_free_valid_in  in  1  commit retires an old physical register
commit_free_preg_in  in  DATA_WIDTH  register to free
commit_free_ready_out  out  1  commit free accepted this cycle
flush_in  in  1  mispredict flush pulse
squash_valid_in  in  1  ROB walk presents a squashed register (no backpressure)
squash_preg_in  in  DATA_WIDTH  squashed register
squash_done_in  in  1  ROB walk finished
fl_dequeue_out  out  1  free list dequeue
fl_rdata_in  in  DATA_WIDTH  free list head data (combinational, same cycle as dequeue)
fl_enqueue_out  out  1  free list enqueue
fl_wdata_out  out  DATA_WIDTH  free list enqueue data
free_count_out  out  $clog2(QUEUE_DEPTH)+1  registered free count
walking_out  out  1  state == WALK
overflow_err_out  out  1  sticky: enqueue attempted at full count

Behaviour:
- Reset, while rst is high:
  - state=RUN, free_count=QUEUE_DEPTH (32), overflow_err=0.
  - All request/ready/enqueue/dequeue outputs are forced to 0.
  - alloc_preg_out and fl_wdata_out are 0.
  - A reset mid-walk returns the block to RUN.
- FSM states: RUN, WALK.
  - RUN -> WALK on flush_in.
  - In WALK, flush_in (nested flush) keeps WALK.
  - WALK -> RUN on the cycle after squash_done_in; squash_done_in in RUN is ignored.
- Allocation, zero-latency combinational:
  - alloc_ready_out = state==RUN && !flush_in && free_count!=0.
  - alloc_valid_out = fl_dequeue_out = alloc_req_in && alloc_ready_out.
  - alloc_preg_out = fl_rdata_in when granted, else 0.
  - fl_empty is never consulted; free_count is authoritative.
- Enqueue arbitration, one per cycle:
  - In WALK, squash has absolute priority. squash_valid_in always enqueues, and commit_free_ready_out = !squash_valid_in.
  - In RUN, squash_valid_in is ignored and commit_free_ready_out=1.
  - A squash arriving in the same cycle as flush_in (state still RUN) is accepted and takes priority.
- Physical register 0 is permanently bound to x0:
  - A commit or squash of preg 0 is accepted (ready high) but not enqueued, and the count is unchanged.
- Count update, registered: next = count + enq - deq.
  - Simultaneous enqueue and dequeue leave the count unchanged.
  - An enqueue at count==QUEUE_DEPTH without a simultaneous dequeue is suppressed (fl_enqueue_out=0) and sets overflow_err_out, which holds until rst.
- free_count_out and walking_out are registered; all other outputs are combinational.

Test Plan:
- Reset then alloc_req_in held 32 cycles: grants 32..63 in order, free_count 32->0; on cycle 33 alloc_ready_out=0 and no dequeue.
- Count=0, commit frees preg 40 while rename requests: no grant that cycle. Next cycle count=1, grant returns 40.
- Same-cycle commit free of 45 and allocation at count=10: fl_enqueue_out=1, fl_dequeue_out=1, count stays 10.
- flush_in pulse, then squash pregs 50,51 with commit_free_valid_in held high:
  - alloc_ready_out=0 from the flush cycle on.
  - commit_free_ready_out=0 during both squash cycles.
  - squash_done_in on cycle 3 gives walking_out=0 and allocation resumes the following cycle.
- Commit free of preg 0: commit_free_ready_out=1, fl_enqueue_out=0, count unchanged.
- At count=32, commit free of 33: enqueue suppressed, overflow_err_out=1, stays high until rst; rst asserted mid-WALK gives RUN, count=32.

Source files
------------

// File: rtl/preg_alloc_ctrl_if.sv
// Signal bundle between the physical-register allocation controller and its
// rename, commit, ROB-walk and free-list neighbours.
interface preg_alloc_ctrl_if #(
  parameter int DATA_WIDTH  = 6,
  parameter int QUEUE_DEPTH = 32
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic                  alloc_req_in;
  logic                  alloc_ready_out;
  logic                  alloc_valid_out;
  logic [DATA_WIDTH-1:0] alloc_preg_out;
  logic                  commit_free_valid_in;
  logic [DATA_WIDTH-1:0] commit_free_preg_in;
  logic                  commit_free_ready_out;
  logic                  flush_in;
  logic                  squash_valid_in;
  logic [DATA_WIDTH-1:0] squash_preg_in;
  logic                  squash_done_in;
  logic                  fl_dequeue_out;
  logic [DATA_WIDTH-1:0] fl_rdata_in;
  logic                  fl_enqueue_out;
  logic [DATA_WIDTH-1:0] fl_wdata_out;
  logic [CW-1:0]         free_count_out;
  logic                  walking_out;
  logic                  overflow_err_out;

  modport master (
    input  alloc_req_in, commit_free_valid_in, commit_free_preg_in,
           flush_in, squash_valid_in, squash_preg_in, squash_done_in, fl_rdata_in,
    output alloc_ready_out, alloc_valid_out, alloc_preg_out, commit_free_ready_out,
           fl_dequeue_out, fl_enqueue_out, fl_wdata_out, free_count_out,
           walking_out, overflow_err_out
  );

  modport slave (
    output alloc_req_in, commit_free_valid_in, commit_free_preg_in,
           flush_in, squash_valid_in, squash_preg_in, squash_done_in, fl_rdata_in,
    input  alloc_ready_out, alloc_valid_out, alloc_preg_out, commit_free_ready_out,
           fl_dequeue_out, fl_enqueue_out, fl_wdata_out, free_count_out,
           walking_out, overflow_err_out
  );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// Physical-register free-list sequencer: one rename grant and one free per cycle,
// squash returns during a flush walk, and an authoritative free count.
module preg_alloc_ctrl #(
  parameter int DATA_WIDTH  = 6,
  parameter int QUEUE_DEPTH = 32
) (
  input logic              clk,
  input logic              rst,
  preg_alloc_ctrl_if.master bus
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         free_count;
  logic [CW-1:0]         count_next;
  logic                  overflow_err;
  logic                  grant;
  logic                  squash_take;
  logic                  commit_ready;
  logic                  commit_take;
  logic                  enq_src;
  logic                  enq_want;
  logic                  enq_fire;
  logic                  overflow_hit;
  logic [DATA_WIDTH-1:0] enq_data;

  // walk state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // flush enters the walk; squash_done leaves it unless a nested flush arrives
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (bus.flush_in) state_next = WALK;
        else              state_next = RUN;
      end
      WALK: begin
        if (bus.flush_in)            state_next = WALK;
        else if (bus.squash_done_in) state_next = RUN;
        else                         state_next = WALK;
      end
      default: state_next = RUN;
    endcase
  end

  // grant, enqueue arbitration and count update
  always_comb begin
    grant        = 1'b0;
    squash_take  = 1'b0;
    commit_ready = 1'b0;
    commit_take  = 1'b0;
    enq_src      = 1'b0;
    enq_want     = 1'b0;
    enq_fire     = 1'b0;
    overflow_hit = 1'b0;
    enq_data     = '0;
    count_next   = free_count;
    if (!rst) begin
      grant = bus.alloc_req_in && (state == RUN) && !bus.flush_in && (free_count != '0);
      // a squash in the flush cycle itself is already part of the walk
      squash_take  = bus.squash_valid_in && ((state == WALK) || bus.flush_in);
      commit_ready = !squash_take;
      commit_take  = bus.commit_free_valid_in && commit_ready;
      enq_src      = squash_take || commit_take;
      if (squash_take) enq_data = bus.squash_preg_in;
      else             enq_data = bus.commit_free_preg_in;
      // preg 0 is hard-wired to x0 and never re-enters the list
      enq_want     = enq_src && (enq_data != '0);
      overflow_hit = enq_want && (free_count == FULL_COUNT) && !grant;
      enq_fire     = enq_want && !overflow_hit;
      count_next   = free_count + CW'(enq_fire) - CW'(grant);
    end else begin
      count_next = FULL_COUNT;
    end
  end

  // free count and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      free_count   <= FULL_COUNT;
      overflow_err <= 1'b0;
    end else begin
      free_count   <= count_next;
      overflow_err <= overflow_err || overflow_hit;
    end
  end

  assign bus.alloc_ready_out       = !rst && (state == RUN) && !bus.flush_in && (free_count != '0);
  assign bus.alloc_valid_out       = grant;
  assign bus.fl_dequeue_out        = grant;
  assign bus.alloc_preg_out        = grant ? bus.fl_rdata_in : '0;
  assign bus.commit_free_ready_out = commit_ready;
  assign bus.fl_enqueue_out        = enq_fire;
  assign bus.fl_wdata_out          = enq_fire ? enq_data : '0;
  assign bus.free_count_out        = free_count;
  assign bus.walking_out           = (state == WALK);
  assign bus.overflow_err_out      = overflow_err;
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Self-checking bench for preg_alloc_ctrl: directed test-plan steps then random
// traffic, all checked against a queue-based free-list reference model.
module tb_preg_alloc_ctrl;
  localparam int DW    = 6;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;

  preg_alloc_ctrl_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH)) bus ();

  preg_alloc_ctrl #(.DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: the free list contents plus walk/overflow flags
  int m_q[$];
  int m_count;
  bit m_walk;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < DEPTH; i++) m_q.push_back(32 + i);
    m_count = DEPTH;
    m_walk  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic idle();
    rst                      = 1'b0;
    bus.alloc_req_in         = 1'b0;
    bus.commit_free_valid_in = 1'b0;
    bus.commit_free_preg_in  = '0;
    bus.flush_in             = 1'b0;
    bus.squash_valid_in      = 1'b0;
    bus.squash_preg_in       = '0;
    bus.squash_done_in       = 1'b0;
  endtask

  // one clock: check combinational outputs, clock, update model, check registers
  task automatic cycle();
    bit e_ready, e_grant, sq_take, e_cready, c_take, want, e_enq, ovf;
    int src, head;
    head = (m_q.size() > 0) ? m_q[0] : 0;
    bus.fl_rdata_in = DW'(head);
    #1;
    e_ready  = !rst && !m_walk && !bus.flush_in && (m_count != 0);
    e_grant  = bus.alloc_req_in && e_ready;
    sq_take  = !rst && bus.squash_valid_in && (m_walk || bus.flush_in);
    e_cready = !rst && !sq_take;
    c_take   = bus.commit_free_valid_in && e_cready;
    src      = sq_take ? int'(bus.squash_preg_in) : int'(bus.commit_free_preg_in);
    want     = (sq_take || c_take) && (src != 0);
    ovf      = want && (m_count == DEPTH) && !e_grant;
    e_enq    = want && !ovf;

    check("alloc_ready", 32'(bus.alloc_ready_out), 32'(e_ready));
    check("alloc_valid", 32'(bus.alloc_valid_out), 32'(e_grant));
    check("fl_dequeue", 32'(bus.fl_dequeue_out), 32'(e_grant));
    check("alloc_preg", 32'(bus.alloc_preg_out), e_grant ? 32'(head) : 32'd0);
    check("commit_ready", 32'(bus.commit_free_ready_out), 32'(e_cready));
    check("fl_enqueue", 32'(bus.fl_enqueue_out), 32'(e_enq));
    check("fl_wdata", 32'(bus.fl_wdata_out), e_enq ? 32'(src) : 32'd0);

    @(posedge clk);
    n_vec++;
    if (rst) begin
      model_reset();
    end else begin
      if (e_grant) void'(m_q.pop_front());
      if (e_enq) m_q.push_back(src);
      m_count = m_count + int'(e_enq) - int'(e_grant);
      m_walk  = bus.flush_in || (m_walk && !bus.squash_done_in);
      m_err   = m_err || ovf;
    end
    #1;
    check("free_count", 32'(bus.free_count_out), 32'(m_count));
    check("walking", 32'(bus.walking_out), 32'(m_walk));
    check("overflow_err", 32'(bus.overflow_err_out), 32'(m_err));
  endtask

  initial begin
    idle();
    bus.fl_rdata_in = '0;
    model_reset();
    @(posedge clk);
    #1;

    // reset
    rst = 1'b1;
    bus.alloc_req_in = 1'b1;
    bus.commit_free_valid_in = 1'b1;
    bus.commit_free_preg_in = 6'd7;
    cycle();
    cycle();
    idle();

    // drain the full list: 32 grants, then a refused request
    bus.alloc_req_in = 1'b1;
    for (int i = 0; i < 33; i++) cycle();

    // empty list: a commit free and a request in the same cycle
    bus.commit_free_valid_in = 1'b1;
    bus.commit_free_preg_in  = 6'd40;
    cycle();
    bus.commit_free_valid_in = 1'b0;
    cycle();
    check("regrant_40_count", 32'(bus.free_count_out), 32'd0);

    // refill to 10, then simultaneous enqueue and dequeue
    bus.alloc_req_in = 1'b0;
    bus.commit_free_valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.commit_free_preg_in = DW'(20 + i);
      cycle();
    end
    bus.alloc_req_in = 1'b1;
    bus.commit_free_preg_in = 6'd45;
    cycle();

    // flush walk with commit frees held high
    bus.flush_in = 1'b1;
    bus.commit_free_preg_in = 6'd12;
    cycle();
    bus.flush_in = 1'b0;
    bus.squash_valid_in = 1'b1;
    bus.squash_preg_in = 6'd50;
    cycle();
    bus.squash_preg_in = 6'd51;
    cycle();
    bus.squash_valid_in = 1'b0;
    bus.squash_done_in = 1'b1;
    cycle();
    bus.squash_done_in = 1'b0;
    cycle();
    idle();

    // commit free of preg 0 is absorbed
    bus.commit_free_valid_in = 1'b1;
    bus.commit_free_preg_in = 6'd0;
    cycle();

    // fill to full, then overflow
    for (int i = 0; i < 64 && m_count < DEPTH; i++) begin
      bus.commit_free_preg_in = DW'(1 + (i % 63));
      cycle();
    end
    bus.commit_free_preg_in = 6'd33;
    cycle();
    idle();
    cycle();
    cycle();
    bus.flush_in = 1'b1;
    cycle();
    bus.flush_in = 1'b0;
    bus.squash_valid_in = 1'b1;
    bus.squash_preg_in = 6'd9;
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    idle();
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst                      = ($urandom_range(0, 63) == 0);
      bus.alloc_req_in         = ($urandom_range(0, 2) != 0);
      bus.commit_free_valid_in = ($urandom_range(0, 1) != 0);
      bus.commit_free_preg_in  = DW'($urandom_range(0, 63));
      bus.flush_in             = ($urandom_range(0, 15) == 0);
      bus.squash_valid_in      = ($urandom_range(0, 1) != 0);
      bus.squash_preg_in       = ($urandom_range(0, 7) == 0) ? 6'd0 : DW'($urandom_range(1, 63));
      bus.squash_done_in       = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
